// File: rtl/stopwatch_input_conditioner_pkg.sv
// Shared types and defaults for the stopwatch input conditioning stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package stopwatch_pkg;

    // 10 ms of stability at 100 MHz before a raw level is accepted
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    // Raw front-panel inputs, grouped so all channels are handled uniformly
    typedef struct packed {
        logic pause;
        logic clr;
        logic adj;
        logic sel;
    } btn_t;

    localparam int NUM_CHANNELS = $bits(btn_t);

endpackage

// File: rtl/stopwatch_input_conditioner_if.sv
// Bundle of raw panel inputs and their conditioned outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are free-running levels or strobes.
interface stopwatch_input_conditioner_if;

    logic pause_btn_i;
    logic clr_btn_i;
    logic adj_sw_i;
    logic sel_sw_i;

    logic pause_o;
    logic pause_pulse_o;
    logic clr_pulse_o;
    logic adj_o;
    logic sel_o;

    // Side that owns the raw panel inputs and consumes the clean outputs
    modport master (
        output pause_btn_i, clr_btn_i, adj_sw_i, sel_sw_i,
        input  pause_o, pause_pulse_o, clr_pulse_o, adj_o, sel_o
    );

    // Conditioner side
    modport slave (
        input  pause_btn_i, clr_btn_i, adj_sw_i, sel_sw_i,
        output pause_o, pause_pulse_o, clr_pulse_o, adj_o, sel_o
    );

endinterface

// File: rtl/stopwatch_input_conditioner_debounce.sv
// One conditioning channel: 2-FF synchroniser, debounce counter, stable level, rise strobe.
// Latency: level/rise commit DEBOUNCE_CYCLES+1 edges after the raw change is first sampled.
// Backpressure: none; a bounce back to the stable level restarts the count.
module debounce_channel
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    logic [CNT_W-1:0] cnt;

    assign s = sync_q[1];

    // Bring the asynchronous raw input into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s;
                cnt   <= '0;
                rise  <= s;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_input_conditioner.sv
// Synchronises and debounces the stopwatch buttons/switches; keeps the pause toggle state.
// Latency: pulses/levels DEBOUNCE_CYCLES+1 edges after first sample; pause_o one edge later.
// Backpressure: none; holding a button yields a single pulse until released and re-pressed.
module stopwatch_input_conditioner
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    stopwatch_input_conditioner_if.slave  io
);

    btn_t                    raw_btn;
    logic [NUM_CHANNELS-1:0] raw_vec;
    logic [NUM_CHANNELS-1:0] level_vec;
    logic [NUM_CHANNELS-1:0] rise_vec;
    btn_t                    level;
    btn_t                    rise;
    logic                    pause_q;
    logic                    unused_bits;

    assign raw_btn.pause = io.pause_btn_i;
    assign raw_btn.clr   = io.clr_btn_i;
    assign raw_btn.adj   = io.adj_sw_i;
    assign raw_btn.sel   = io.sel_sw_i;
    assign raw_vec       = raw_btn;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_vec[i]),
            .level (level_vec[i]),
            .rise  (rise_vec[i])
        );
    end

    assign level = btn_t'(level_vec);
    assign rise  = btn_t'(rise_vec);

    // Button levels and switch rises have no downstream consumer
    assign unused_bits = ^{level.pause, level.clr, rise.adj, rise.sel};

    // Pause toggles on each press; a clear press forces it off and takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_q <= 1'b0;
        end else if (rise.clr) begin
            pause_q <= 1'b0;
        end else if (rise.pause) begin
            pause_q <= ~pause_q;
        end
    end

    assign io.pause_o       = pause_q;
    assign io.pause_pulse_o = rise.pause;
    assign io.clr_pulse_o   = rise.clr;
    assign io.adj_o         = level.adj;
    assign io.sel_o         = level.sel;

endmodule

// File: tb/tb_stopwatch_input_conditioner.sv
// Self-checking bench for stopwatch_input_conditioner with a window-based reference model.
// Latency: checks every cycle, 1 time unit after the rising clk edge.
// Backpressure: n/a.
module tb_stopwatch_input_conditioner;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    stopwatch_input_conditioner_if sw_if ();

    stopwatch_input_conditioner #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (sw_if)
    );

    int compared   = 0;
    int mismatched = 0;

    // channel index: 0 pause, 1 clr, 2 adj, 3 sel
    bit           raw     [4];
    bit           m_ff1   [4];
    bit           m_s     [4];
    bit           m_level [4];
    bit           m_rise  [4];
    logic [D-1:0] m_win   [4];
    bit           m_pause;
    int           pp_cnt;
    int           cp_cnt;
    int           hold    [4];

    task automatic chk(input string tag, input logic obs, input bit exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        compared++;
        assert (obs == exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_ff1[c]   = 1'b0;
            m_s[c]     = 1'b0;
            m_level[c] = 1'b0;
            m_rise[c]  = 1'b0;
            m_win[c]   = '0;
        end
        m_pause = 1'b0;
    endtask

    // A level is accepted when the last D synchronised samples all disagree with it
    task automatic model_edge();
        bit prev_rise [4];
        for (int c = 0; c < 4; c++) prev_rise[c] = m_rise[c];
        for (int c = 0; c < 4; c++) begin
            m_win[c]  = {m_win[c][D-2:0], m_s[c]};
            m_rise[c] = 1'b0;
            if (m_win[c] == {D{~m_level[c]}}) begin
                m_level[c] = ~m_level[c];
                m_rise[c]  = m_level[c];
            end
            m_s[c]   = m_ff1[c];
            m_ff1[c] = raw[c];
        end
        if (prev_rise[1])      m_pause = 1'b0;
        else if (prev_rise[0]) m_pause = ~m_pause;
    endtask

    task automatic drive();
        sw_if.pause_btn_i = raw[0];
        sw_if.clr_btn_i   = raw[1];
        sw_if.adj_sw_i    = raw[2];
        sw_if.sel_sw_i    = raw[3];
    endtask

    task automatic check_all();
        chk("pause_o",       sw_if.pause_o,       m_pause);
        chk("pause_pulse_o", sw_if.pause_pulse_o, m_rise[0]);
        chk("clr_pulse_o",   sw_if.clr_pulse_o,   m_rise[1]);
        chk("adj_o",         sw_if.adj_o,         m_level[2]);
        chk("sel_o",         sw_if.sel_o,         m_level[3]);
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (sw_if.pause_pulse_o === 1'b1) pp_cnt++;
        if (sw_if.clr_pulse_o === 1'b1)   cp_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_all(input bit v);
        for (int c = 0; c < 4; c++) raw[c] = v;
    endtask

    initial begin
        // Reset with every raw input already high
        rst_n = 1'b0;
        set_all(1'b1);
        drive();
        model_reset();
        #3;
        check_all();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_all();
        end

        // Release: inputs high at release count as fresh presses, pulses at edge 6
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("rel_pause_pulse", sw_if.pause_pulse_o, e == 6);
            chk("rel_clr_pulse",   sw_if.clr_pulse_o,   e == 6);
            chk("rel_adj",         sw_if.adj_o,         e >= 6);
        end
        chk("rel_pause_o_clr_wins", sw_if.pause_o, 1'b0);

        set_all(1'b0);
        run(12);

        // Clean press, release, press again
        raw[0] = 1'b1; run(10);
        chk("press1_pause_o", sw_if.pause_o, 1'b1);
        raw[0] = 1'b0; run(10);
        raw[0] = 1'b1; run(10);
        chk("press2_pause_o", sw_if.pause_o, 1'b0);
        raw[0] = 1'b0; run(10);

        // Bounce settling low: no pulse
        pp_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            raw[0] = ((i / 2) % 2) == 0;
            step();
        end
        raw[0] = 1'b0; run(10);
        chk_int("bounce_low_pulses", pp_cnt, 0);
        chk("bounce_low_pause_o", sw_if.pause_o, 1'b0);

        // Bounce settling high: exactly one pulse
        pp_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            raw[0] = ((i / 2) % 2) == 0;
            step();
        end
        raw[0] = 1'b1; run(10);
        chk_int("bounce_high_pulses", pp_cnt, 1);
        chk("bounce_high_pause_o", sw_if.pause_o, 1'b1);
        raw[0] = 1'b0; run(10);

        // Clear while paused
        cp_cnt = 0;
        raw[1] = 1'b1; run(10);
        chk_int("clr_pulses", cp_cnt, 1);
        chk("clr_pause_o", sw_if.pause_o, 1'b0);
        raw[1] = 1'b0; run(10);

        // Pause then simultaneous pause+clear
        raw[0] = 1'b1; run(10);
        chk("pre_both_pause_o", sw_if.pause_o, 1'b1);
        raw[0] = 1'b0; run(10);
        pp_cnt = 0;
        cp_cnt = 0;
        raw[0] = 1'b1;
        raw[1] = 1'b1;
        run(10);
        chk_int("both_pause_pulses", pp_cnt, 1);
        chk_int("both_clr_pulses",   cp_cnt, 1);
        chk("both_pause_o", sw_if.pause_o, 1'b0);
        set_all(1'b0); run(10);

        // Switches: adj follows slow changes, short sel glitch is rejected
        raw[2] = 1'b1; run(10);
        chk("adj_high", sw_if.adj_o, 1'b1);
        raw[2] = 1'b0; run(10);
        chk("adj_low", sw_if.adj_o, 1'b0);
        raw[3] = 1'b1; run(3);
        raw[3] = 1'b0; run(10);
        chk("sel_glitch", sw_if.sel_o, 1'b0);

        // Reset in the middle of a pause debounce, button held throughout
        raw[0] = 1'b1; run(4);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        pp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all();
            if (sw_if.pause_pulse_o === 1'b1) pp_cnt++;
        end
        chk_int("midrst_no_pulse", pp_cnt, 0);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("midrst_pulse", sw_if.pause_pulse_o, e == 6);
        end
        raw[0] = 1'b0; run(10);

        // Randomised hold times around the debounce window on all channels
        for (int c = 0; c < 4; c++) hold[c] = $urandom_range(1, 2 * D + 2);
        for (int t = 0; t < 600; t++) begin
            for (int c = 0; c < 4; c++) begin
                hold[c]--;
                if (hold[c] == 0) begin
                    raw[c]  = ~raw[c];
                    hold[c] = $urandom_range(1, 2 * D + 2);
                end
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
